osc_pwm_output: RTL and testbench

- Output stage directly downstream of the oscillator block.
- Consumes the two's-complement o_main_osc / o_sub_osc samples.
- Mixes them with saturation, applies a click-free soft-mute gain ramp, and drives a single-bit PWM audio pin on the 25 MHz system clock.
- Also emits a sample-rate tick so other blocks can align to the output sample boundary.

---
 rtl/osc_pwm_output.sv | 145 ++++++++++++++
 tb/tb_osc_pwm_output.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/osc_pwm_output.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// osc_pwm_output: saturating main/sub oscillator mix, soft-mute gain ramp and
// single-bit PWM audio output with a per-sample tick.
// Revision: 1.0
// ============================================================================
module osc_pwm_output #(
  parameter int OSC_WIDTH = 8,
  parameter int SUB_SHIFT = 1,
  parameter int RAMP_STEP = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [OSC_WIDTH-1:0] i_main_osc,
  input  logic [OSC_WIDTH-1:0] i_sub_osc,
  input  logic                 i_mute,
  output logic                 o_pwm,
  output logic                 o_sample_tick,
  output logic                 o_muted,
  output logic [OSC_WIDTH-1:0] o_duty
);

  localparam int                   PROD_W     = OSC_WIDTH + 10;
  localparam logic [OSC_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [OSC_WIDTH-1:0] DUTY_MID   = {1'b1, {(OSC_WIDTH-1){1'b0}}};
  localparam logic [OSC_WIDTH-1:0] SAT_NEG    = {1'b1, {(OSC_WIDTH-1){1'b0}}};
  localparam logic [OSC_WIDTH-1:0] SAT_POS    = {1'b0, {(OSC_WIDTH-1){1'b1}}};
  localparam logic [8:0]           GAIN_UNITY = 9'd256;
  localparam logic [9:0]           STEP_W     = 10'(RAMP_STEP);

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                       state, state_next;
  logic [8:0]                   gain, gain_next;
  logic [9:0]                   gain_up;
  logic [OSC_WIDTH-1:0]         pwm_cnt;
  logic                         wrap;

  logic signed [OSC_WIDTH:0]    main_ext, sub_ext, sub_shifted, mix;
  logic signed [OSC_WIDTH-1:0]  mix_sat, mix_sat_next;
  logic signed [PROD_W-1:0]     product;
  logic signed [OSC_WIDTH-1:0]  scaled;
  logic [OSC_WIDTH-1:0]         duty_pipe;

  assign wrap = (pwm_cnt == CNT_MAX);

  // Stage 1: one extra bit of headroom, then clamp back to OSC_WIDTH.
  assign main_ext    = $signed({i_main_osc[OSC_WIDTH-1], i_main_osc});
  assign sub_ext     = $signed({i_sub_osc[OSC_WIDTH-1], i_sub_osc});
  assign sub_shifted = sub_ext >>> SUB_SHIFT;
  assign mix         = main_ext + sub_shifted;

  always_comb begin
    mix_sat_next = mix[OSC_WIDTH-1:0];
    if (mix[OSC_WIDTH] != mix[OSC_WIDTH-1]) begin
      mix_sat_next = mix[OSC_WIDTH] ? SAT_NEG : SAT_POS;
    end
  end

  // Stage 2: gain 256 is exact unity, so the >>>8 floor is lossless there.
  assign product = PROD_W'($signed({1'b0, gain})) * PROD_W'(mix_sat);
  assign scaled  = OSC_WIDTH'(product >>> 8);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pwm_cnt   <= '0;
      mix_sat   <= '0;
      duty_pipe <= '0;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      mix_sat   <= mix_sat_next;
      duty_pipe <= {~scaled[OSC_WIDTH-1], scaled[OSC_WIDTH-2:0]};
    end
  end

  assign gain_up = {1'b0, gain} + STEP_W;

  always_comb begin
    state_next = state;
    gain_next  = gain;
    case (state)
      MUTED: begin
        gain_next = '0;
        if (!i_mute) state_next = RAMP_UP;
      end
      RAMP_UP: begin
        if (i_mute) begin
          state_next = RAMP_DOWN;
        end else if (gain_up >= {1'b0, GAIN_UNITY}) begin
          gain_next  = GAIN_UNITY;
          state_next = ACTIVE;
        end else begin
          gain_next = gain_up[8:0];
        end
      end
      ACTIVE: begin
        gain_next = GAIN_UNITY;
        if (i_mute) state_next = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!i_mute) begin
          state_next = RAMP_UP;
        end else if ({1'b0, gain} <= STEP_W) begin
          gain_next  = '0;
          state_next = MUTED;
        end else begin
          gain_next = gain - STEP_W[8:0];
        end
      end
      default: begin
        gain_next  = '0;
        state_next = MUTED;
      end
    endcase
  end

  // Gain, state and duty all move only on the period boundary.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= MUTED;
      gain          <= '0;
      o_muted       <= 1'b1;
      o_duty        <= DUTY_MID;
      o_pwm         <= 1'b0;
      o_sample_tick <= 1'b0;
    end else begin
      if (wrap) begin
        state   <= state_next;
        gain    <= gain_next;
        o_muted <= (state_next == MUTED);
        o_duty  <= duty_pipe;
      end
      o_pwm         <= (pwm_cnt < o_duty);
      o_sample_tick <= wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_osc_pwm_output.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_osc_pwm_output: directed self-checking bench for osc_pwm_output.
// Revision: 1.0
// ============================================================================
module tb_osc_pwm_output;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] main_osc, sub_osc;
  logic       mute;
  logic       pwm, sample_tick, muted;
  logic [7:0] duty;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  osc_pwm_output #(
    .OSC_WIDTH(8),
    .SUB_SHIFT(1),
    .RAMP_STEP(1)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_main_osc   (main_osc),
    .i_sub_osc    (sub_osc),
    .i_mute       (mute),
    .o_pwm        (pwm),
    .o_sample_tick(sample_tick),
    .o_muted      (muted),
    .o_duty       (duty)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the negedge of the next cycle with the sample tick high.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 300);
    check("tick_seen", int'(sample_tick), 1);
  endtask

  // Samples 256 cycles starting at the current (tick) cycle.
  task automatic measure_period(output int high, output int ticks);
    high  = 0;
    ticks = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm) high++;
      if (sample_tick) ticks++;
      @(negedge clk);
    end
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int high, ticks, n, prev, bad, changed;

    // Reset and hold muted.
    rst = 1'b1; mute = 1'b1; main_osc = 8'd100; sub_osc = 8'd50;
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 128);
    check("rst_muted", muted, 1);
    check("rst_pwm", pwm, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_gain", dut.gain, 0);
    rst = 1'b0;

    wait_tick();
    for (int p = 0; p < 4; p++) begin
      measure_period(high, ticks);
      check("mute_pwm_high", high, 128);
      check("mute_tick_count", ticks, 1);
      check("mute_duty", duty, 128);
      check("mute_muted", muted, 1);
    end

    // Ramp up to gain 129, reverse briefly, then resume to unity.
    mute = 1'b0; main_osc = 8'd100; sub_osc = 8'd0;
    prev = duty; bad = 0; n = 0;
    do begin
      wait_tick();
      n++;
      if (duty < prev || duty > 228) bad++;
      prev = duty;
    end while (dut.gain != 129 && n < 300);
    check("ramp1_monotonic", bad, 0);
    check("ramp1_gain", dut.gain, 129);
    check("ramp1_muted", muted, 0);

    mute = 1'b1;
    wait_tick();
    check("rev_down_hold_gain", dut.gain, 129);
    wait_tick();
    check("rev_down_step_gain", dut.gain, 128);
    mute = 1'b0;
    wait_tick();
    check("rev_up_hold_gain", dut.gain, 128);
    check("rev_up_muted", muted, 0);
    wait_tick();
    check("rev_up_step_gain", dut.gain, 129);

    prev = duty; bad = 0; n = 0;
    do begin
      wait_tick();
      n++;
      if (duty < prev || duty > 228) bad++;
      prev = duty;
    end while (duty != 228 && n < 300);
    check("ramp2_monotonic", bad, 0);
    check("ramp2_final_duty", duty, 228);
    check("ramp2_gain_unity", dut.gain, 256);
    check("ramp2_periods", n, 128);

    // Saturation at both rails.
    main_osc = 8'd127; sub_osc = 8'd127;
    repeat (3) wait_tick();
    check("sat_pos_duty", duty, 255);
    measure_period(high, ticks);
    check("sat_pos_pwm_high", high, 255);

    main_osc = 8'h80; sub_osc = 8'h80;
    repeat (3) wait_tick();
    check("sat_neg_duty", duty, 0);
    measure_period(high, ticks);
    check("sat_neg_pwm_high", high, 0);

    // Input change mid-period must not alter the duty until the wrap.
    main_osc = 8'd10; sub_osc = 8'd0;
    repeat (3) wait_tick();
    check("mid_duty_before", duty, 138);
    repeat (100) @(negedge clk);
    check("mid_cnt_align", dut.pwm_cnt, 100);
    main_osc = 8'd60;
    changed = 0;
    for (int i = 0; i < 155; i++) begin
      @(negedge clk);
      if (duty != 138) changed++;
    end
    check("mid_no_change", changed, 0);
    @(negedge clk);
    check("mid_wrap_tick", sample_tick, 1);
    check("mid_duty_after", duty, 188);

    // Ramp down a little, then reset mid-period.
    mute = 1'b1;
    repeat (3) wait_tick();
    check("down_gain", dut.gain, 254);
    repeat (77) @(negedge clk);
    check("rst_cnt_align", dut.pwm_cnt, 77);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cnt", dut.pwm_cnt, 0);
    check("midrst_duty", duty, 128);
    check("midrst_pwm", pwm, 0);
    check("midrst_muted", muted, 1);
    check("midrst_gain", dut.gain, 0);
    check("midrst_tick", sample_tick, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
